// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-core data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int NCORES_DEF = 2;
  localparam int LMEM_DEF   = 8;
  localparam int TAM_DEF    = 16;

  // Address bit that selects the shared region (default geometry).
  localparam int SHARED_BIT = LMEM_DEF;

  // Load return depth: issue -> capture -> rdata/rvalid.
  localparam int LD_STAGES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND0 = 2'd1,
    ST_PEND1 = 2'd2
  } arb_state_e;

  // Per-cycle arbitration decision.
  typedef struct packed {
    logic conflict;
    logic winner;
  } arb_dec_t;

  // Pending state that guarantees the given core wins the next conflict.
  function automatic arb_state_e pend_of(input logic core);
    return core ? ST_PEND1 : ST_PEND0;
  endfunction

endpackage

// File: rtl/dmem_port_reg.sv
// Per-port issue register plus load return pipe.
// An accepted request is registered onto the memory port for one cycle;
// loads capture memory data at the end of the issue cycle and present it
// one cycle later with a single-cycle rvalid.
module dmem_port_reg
  import dmem_arbiter_pkg::*;
#(
  parameter int TAM = TAM_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           acc,
  input  logic           we,
  input  logic [TAM-1:0] addr,
  input  logic [TAM-1:0] wdata,
  input  logic [TAM-1:0] dout,
  output logic [TAM-1:0] data_in,
  output logic [TAM-1:0] data_addr,
  output logic           write,
  output logic           load,
  output logic [TAM-1:0] rdata,
  output logic           rvalid
);

  logic [TAM-1:0]     addr_q, addr_d;
  logic [TAM-1:0]     wdata_q, wdata_d;
  logic [TAM-1:0]     cap_q, cap_d;
  logic [TAM-1:0]     rdata_q, rdata_d;
  logic               write_q, write_d;
  logic [LD_STAGES:0] vld_pipe_q, vld_pipe_d;

  // Next-state: port regs hold last issued values; vld_pipe[0] is the load strobe.
  always_comb begin
    addr_d     = acc ? addr  : addr_q;
    wdata_d    = acc ? wdata : wdata_q;
    write_d    = acc & we;
    vld_pipe_d = {vld_pipe_q[LD_STAGES-1:0], acc & ~we};
    cap_d      = vld_pipe_q[0] ? dout  : cap_q;
    rdata_d    = vld_pipe_q[1] ? cap_q : rdata_q;
  end

  // Port and return-pipe registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      cap_q      <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      write_q    <= write_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign data_in   = wdata_q;
  assign data_addr = addr_q;
  assign write     = write_q;
  assign load      = vld_pipe_q[0];
  assign rdata     = rdata_q;
  assign rvalid    = vld_pipe_q[LD_STAGES];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-core data-memory arbiter. Each core owns its memory port; only
// shared-region accesses that involve a store can collide. Collisions are
// resolved by a rotating priority plus a one-cycle pending grant so no core
// stalls for more than one consecutive cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int Ncores = NCORES_DEF,
  parameter int Lmem   = LMEM_DEF,
  parameter int TAM    = TAM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [TAM-1:0]    addr0,
  input  logic [TAM-1:0]    addr1,
  input  logic [TAM-1:0]    wdata0,
  input  logic [TAM-1:0]    wdata1,
  output logic              stall0,
  output logic              stall1,
  output logic [TAM-1:0]    rdata0,
  output logic [TAM-1:0]    rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              err0,
  output logic              err1,
  output logic [TAM-1:0]    dataIN0,
  output logic [TAM-1:0]    dataIN1,
  output logic [TAM-1:0]    dataADDR0,
  output logic [TAM-1:0]    dataADDR1,
  output logic [Ncores-1:0] dataWrite,
  output logic [Ncores-1:0] dataLoad,
  input  logic [TAM-1:0]    dataOUT0,
  input  logic [TAM-1:0]    dataOUT1
);

  logic [Ncores-1:0]          req, we, in_rng, shr, cand, stall, acc;
  logic [Ncores-1:0]          rvalid, err_q, err_d;
  logic [Ncores-1:0][TAM-1:0] addr_v, wdata_v, dout_v, din_v, dadr_v, rdata_v;

  arb_state_e state_q, state_d;
  logic       prio_q, prio_d;
  arb_dec_t   dec;

  assign req     = {req1, req0};
  assign we      = {we1, we0};
  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};
  assign dout_v  = {dataOUT1, dataOUT0};

  // Range check and shared-region decode per core.
  always_comb begin
    for (int i = 0; i < Ncores; i++) begin
      in_rng[i] = (addr_v[i][TAM-1:Lmem+1] == '0);
      shr[i]    = addr_v[i][Lmem];
    end
    cand = req & in_rng;
  end

  // Conflict detect and winner pick; a pending core beats the rotating pointer.
  always_comb begin
    dec.conflict = cand[0] & cand[1] & shr[0] & shr[1] & (we[0] | we[1]);
    case (state_q)
      ST_PEND0: dec.winner = 1'b0;
      ST_PEND1: dec.winner = 1'b1;
      default:  dec.winner = prio_q;
    endcase
  end

  // Only the conflict loser stalls; stall is forced low during reset.
  always_comb begin
    stall[0] = rst & dec.conflict &  dec.winner;
    stall[1] = rst & dec.conflict & ~dec.winner;
    acc      = cand & ~stall;
    err_d    = req & ~in_rng;
  end

  // FSM/priority next-state: a conflict parks the loser in PEND<loser>; with no
  // conflict the pending core either issues or has dropped req, so go idle.
  always_comb begin
    state_d = ST_IDLE;
    prio_d  = prio_q;
    if (dec.conflict) begin
      state_d = pend_of(~dec.winner);
      prio_d  = ~dec.winner;
    end
  end

  // Arbiter state and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < Ncores; i++) begin : g_port
    dmem_port_reg #(.TAM(TAM)) u_port (
      .clk       (clk),
      .rst       (rst),
      .acc       (acc[i]),
      .we        (we[i]),
      .addr      (addr_v[i]),
      .wdata     (wdata_v[i]),
      .dout      (dout_v[i]),
      .data_in   (din_v[i]),
      .data_addr (dadr_v[i]),
      .write     (dataWrite[i]),
      .load      (dataLoad[i]),
      .rdata     (rdata_v[i]),
      .rvalid    (rvalid[i])
    );
  end

  assign stall0    = stall[0];
  assign stall1    = stall[1];
  assign rdata0    = rdata_v[0];
  assign rdata1    = rdata_v[1];
  assign rvalid0   = rvalid[0];
  assign rvalid1   = rvalid[1];
  assign err0      = err_q[0];
  assign err1      = err_q[1];
  assign dataIN0   = din_v[0];
  assign dataIN1   = din_v[1];
  assign dataADDR0 = dadr_v[0];
  assign dataADDR1 = dadr_v[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a flat word-memory model on both ports.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        stall0, stall1, rvalid0, rvalid1, err0, err1;
  logic [15:0] rdata0, rdata1, dataIN0, dataIN1, dataADDR0, dataADDR1;
  logic [1:0]  dataWrite, dataLoad;
  logic [15:0] dataOUT0, dataOUT1;

  logic [15:0] mem [0:511];

  int          n_chk = 0;
  int          n_bad = 0;
  int          w;
  logic [15:0] exp_sh;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .stall0(stall0), .stall1(stall1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .err0(err0), .err1(err1),
    .dataIN0(dataIN0), .dataIN1(dataIN1),
    .dataADDR0(dataADDR0), .dataADDR1(dataADDR1),
    .dataWrite(dataWrite), .dataLoad(dataLoad),
    .dataOUT0(dataOUT0), .dataOUT1(dataOUT1)
  );

  // Memory model: combinational read, write at the end of the issue cycle.
  always_ff @(posedge clk) begin
    if (dataWrite[0]) mem[dataADDR0[8:0]] <= dataIN0;
    if (dataWrite[1]) mem[dataADDR1[8:0]] <= dataIN1;
  end
  assign dataOUT0 = mem[dataADDR0[8:0]];
  assign dataOUT1 = mem[dataADDR1[8:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic do_reset;
    idle_all();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    idle_all();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state, with a conflicting request pattern held during reset.
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 16'h0105; addr1 = 16'h0105;
    #1;
    chk("rst_stall0", 32'(stall0), 0);
    chk("rst_stall1", 32'(stall1), 0);
    tick(); tick();
    chk("rst_dwrite", 32'(dataWrite), 0);
    chk("rst_dload",  32'(dataLoad), 0);
    chk("rst_rvalid", 32'({rvalid1, rvalid0}), 0);
    chk("rst_err",    32'({err1, err0}), 0);
    chk("rst_daddr0", 32'(dataADDR0), 0);
    chk("rst_din1",   32'(dataIN1), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    idle_all();
    rst = 1'b1;
    tick();

    // Private store then load on core0.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0012; wdata0 = 16'hBEEF;
    #1 chk("p_stall0", 32'(stall0), 0);
    tick();
    chk("p_dwrite",  32'(dataWrite), 32'h1);
    chk("p_daddr0",  32'(dataADDR0), 32'h0012);
    chk("p_din0",    32'(dataIN0), 32'hBEEF);
    we0 = 1'b0;
    tick();
    chk("p_dwrite_off", 32'(dataWrite), 0);
    chk("p_dload",      32'(dataLoad), 32'h1);
    chk("p_rv_early0",  32'(rvalid0), 0);
    req0 = 1'b0;
    tick();
    chk("p_dload_off",  32'(dataLoad), 0);
    chk("p_rv_early1",  32'(rvalid0), 0);
    tick();
    chk("p_rvalid0",    32'(rvalid0), 1);
    chk("p_rdata0",     32'(rdata0), 32'hBEEF);
    tick();
    chk("p_rv_pulse",   32'(rvalid0), 0);
    chk("p_addr_hold",  32'(dataADDR0), 32'h0012);

    // First shared conflict after reset: core0 wins.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 16'h0105; addr1 = 16'h0105; wdata0 = 16'h1111; wdata1 = 16'h2222;
    #1;
    chk("s_stall0", 32'(stall0), 0);
    chk("s_stall1", 32'(stall1), 1);
    tick();
    chk("s_win0",   32'(dataWrite), 32'h1);
    chk("s_din0",   32'(dataIN0), 32'h1111);
    chk("s_daddr0", 32'(dataADDR0), 32'h0105);
    req0 = 1'b0;
    #1 chk("s_stall1_rel", 32'(stall1), 0);
    tick();
    chk("s_win1",   32'(dataWrite), 32'h2);
    chk("s_din1",   32'(dataIN1), 32'h2222);
    idle_all();
    tick();
    chk("s_mem",    32'(mem[9'h105]), 32'h2222);

    // Eight conflicts: winner alternates, loser issues on the following cycle.
    w = 1;
    for (int k = 0; k < 8; k++) begin
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
      wdata0 = 16'(32'h3000 + k); wdata1 = 16'(32'h4000 + k);
      #1;
      chk("c_stall0", 32'(stall0), 32'(w == 1));
      chk("c_stall1", 32'(stall1), 32'(w == 0));
      tick();
      chk("c_win", 32'(dataWrite), (w == 0) ? 32'h1 : 32'h2);
      if (w == 0) req0 = 1'b0; else req1 = 1'b0;
      #1 chk("c_nostall", 32'({stall1, stall0}), 0);
      tick();
      chk("c_lose", 32'(dataWrite), (w == 0) ? 32'h2 : 32'h1);
      exp_sh = (w == 0) ? wdata1 : wdata0;
      idle_all();
      w = 1 - w;
    end

    // Shared load/load never stalls; both return together.
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    #1 chk("ll_stall", 32'({stall1, stall0}), 0);
    tick();
    chk("ll_dload", 32'(dataLoad), 32'h3);
    idle_all();
    tick();
    chk("ll_rv_early", 32'({rvalid1, rvalid0}), 0);
    tick();
    chk("ll_rvalid", 32'({rvalid1, rvalid0}), 32'h3);
    chk("ll_rdata0", 32'(rdata0), 32'(exp_sh));
    chk("ll_rdata1", 32'(rdata1), 32'(exp_sh));

    // Out-of-range load on core1.
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0300;
    #1 chk("oor_stall1", 32'(stall1), 0);
    tick();
    chk("oor_err1",  32'(err1), 1);
    chk("oor_err0",  32'(err0), 0);
    chk("oor_dload", 32'(dataLoad), 0);
    idle_all();
    tick();
    chk("oor_err_pulse", 32'(err1), 0);
    tick();
    chk("oor_rv1a", 32'(rvalid1), 0);
    tick();
    chk("oor_rv1b", 32'(rvalid1), 0);

    // Reset while PEND1 with a core0 load in flight.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0105;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0105; wdata1 = 16'h5555;
    #1;
    chk("r_stall1", 32'(stall1), 1);
    chk("r_stall0", 32'(stall0), 0);
    tick();
    chk("r_dload", 32'(dataLoad), 32'h1);
    req0 = 1'b0;
    rst = 1'b0;
    #1;
    chk("r_dload_clr",  32'(dataLoad), 0);
    chk("r_dwrite_clr", 32'(dataWrite), 0);
    chk("r_stall_clr",  32'({stall1, stall0}), 0);
    chk("r_daddr0_clr", 32'(dataADDR0), 0);
    chk("r_rdata0_clr", 32'(rdata0), 0);
    idle_all();
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("r_rv_after",  32'({rvalid1, rvalid0}), 0);
    chk("r_dw_after",  32'(dataWrite), 0);
    tick();
    chk("r_rv_after2", 32'({rvalid1, rvalid0}), 0);
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    #1;
    chk("r_re_stall0", 32'(stall0), 0);
    chk("r_re_stall1", 32'(stall1), 1);
    tick();
    chk("r_re_win0", 32'(dataWrite), 32'h1);
    idle_all();
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
